// File: rtl/chunked_adder_unit.sv
// chunked_adder_unit: multi-cycle adder, DIGIT bits per clock, optional subtract via CHUNKED_ADDER_SUB_EN
module chunked_adder_unit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LoadB,
    input  logic             Run,
    input  logic             Accum,
`ifdef CHUNKED_ADDER_SUB_EN
    input  logic             Sub,
`endif
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] Sum,
    output logic             CO,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, next;
    logic [WIDTH-1:0] b, op_a, op_b, partial, merged;
    logic             carry, sub, start, last;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   add;

`ifdef CHUNKED_ADDER_SUB_EN
    assign sub = Sub;
`else
    assign sub = 1'b0;
`endif

    assign start = Run && !LoadB;
    assign last  = cnt == CW'(N - 1);
    assign add   = {1'b0, op_a[cnt*DIGIT +: DIGIT]} + {1'b0, op_b[cnt*DIGIT +: DIGIT]} + {{DIGIT{1'b0}}, carry};
    assign Busy  = state == CALC;
    assign Done  = state == DONE;

    // partial result with the current chunk written in, so the last chunk can go straight to Sum
    always_comb begin
        merged = partial;
        merged[cnt*DIGIT +: DIGIT] = add[DIGIT-1:0];
    end

    // next-state logic
    always_comb begin
        next = state;
        next = (state == IDLE && start) ? CALC :
               (state == CALC && last)  ? DONE :
               (state == DONE)          ? IDLE : state;
    end

    // state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= next;
    end

    // datapath: operand capture, chunk adds, and result update on the final chunk
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            b        <= '0;
            op_a     <= '0;
            op_b     <= '0;
            partial  <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            Sum      <= '0;
            CO       <= 1'b0;
            Overflow <= 1'b0;
        end else if (state == IDLE) begin
            if (LoadB) b <= SW;
            else if (Run) begin
                op_a  <= Accum ? Sum : SW;
                op_b  <= sub ? ~b : b;
                carry <= sub;
                cnt   <= '0;
            end
        end else if (state == CALC) begin
            partial <= merged;
            carry   <= add[DIGIT];
            cnt     <= cnt + 1'b1;
            if (last) begin
                Sum      <= merged;
                CO       <= add[DIGIT];
                Overflow <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add[DIGIT-1] != op_a[WIDTH-1]);
            end
        end
    end
endmodule

// File: tb/tb_chunked_adder_unit.sv
// tb_chunked_adder_unit: table-driven check of chunked_adder_unit (CHUNKED_ADDER_SUB_EN selects the DIGIT=1 subtract build)
module tb_chunked_adder_unit;
`ifdef CHUNKED_ADDER_SUB_EN
    localparam int DIG = 1;
`else
    localparam int DIG = 4;
`endif
    localparam int N = 16 / DIG;

    logic        Clk = 0, Reset = 0, LoadB = 0, Run = 0, Accum = 0, sub_in = 0;
    logic [15:0] SW = 0, Sum;
    logic        CO, Overflow, Busy, Done;
    int          checks = 0, fails = 0, dones = 0;

    chunked_adder_unit #(.WIDTH(16), .DIGIT(DIG)) dut (
        .Clk(Clk), .Reset(Reset), .LoadB(LoadB), .Run(Run), .Accum(Accum),
`ifdef CHUNKED_ADDER_SUB_EN
        .Sub(sub_in),
`endif
        .SW(SW), .Sum(Sum), .CO(CO), .Overflow(Overflow), .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    // count Done pulses away from the active edge
    always @(negedge Clk) if (Done) dones++;

    typedef struct {
        logic        load;
        logic [15:0] b, a;
        logic        acc;
        logic [15:0] sum;
        logic        co, ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_b(input logic [15:0] v);
        @(negedge Clk); SW = v; LoadB = 1;
        @(negedge Clk); LoadB = 0;
    endtask

    task automatic run_op(input logic [15:0] a, input logic acc, input logic sb, output int lat, output int busy, output logic held);
        logic [15:0] prev;
        @(negedge Clk); SW = a; Accum = acc; sub_in = sb; Run = 1;
        @(negedge Clk); Run = 0;
        lat = 1; busy = 0; held = 1; prev = Sum;
        while (!Done && lat < 200) begin
            busy += int'(Busy);
            if (Sum !== prev) held = 0;
            @(negedge Clk); lat++;
        end
    endtask

    task automatic run_check(input string name, input logic [15:0] a, input logic acc, input logic sb,
                             input logic [15:0] s, input logic co, input logic ov);
        int lat, busy; logic held;
        run_op(a, acc, sb, lat, busy, held);
        check({name, " latency"}, lat, N + 1);
        check({name, " busy"}, busy, N);
        check({name, " held"}, {31'b0, held}, 1);
        check({name, " busy_in_done"}, {31'b0, Busy}, 0);
        check({name, " sum"}, {16'b0, Sum}, {16'b0, s});
        check({name, " co"}, {31'b0, CO}, {31'b0, co});
        check({name, " ov"}, {31'b0, Overflow}, {31'b0, ov});
        @(negedge Clk);
        check({name, " done_pulse"}, {31'b0, Done}, 0);
    endtask

    initial begin
        vec_t vt[6];
        int   d0, lat;
        vt[0] = '{1, 16'h0002, 16'h0001, 0, 16'h0003, 0, 0};
        vt[1] = '{1, 16'h14DB, 16'hF232, 0, 16'h070D, 1, 0};
        vt[2] = '{1, 16'h0001, 16'hFFFF, 0, 16'h0000, 1, 0};
        vt[3] = '{0, 16'h0000, 16'h0000, 1, 16'h0001, 0, 0};
        vt[4] = '{1, 16'h0001, 16'h7FFF, 0, 16'h8000, 0, 1};
        vt[5] = '{1, 16'h8000, 16'h8000, 0, 16'h0000, 1, 1};

        Reset = 1;
        repeat (2) @(negedge Clk);
        check("reset sum", {16'b0, Sum}, 0);
        check("reset flags", {28'b0, CO, Overflow, Busy, Done}, 0);
        Reset = 0;

        for (int i = 0; i < 6; i++) begin
            if (vt[i].load) load_b(vt[i].b);
            run_check($sformatf("vec%0d", i), vt[i].a, vt[i].acc, 1'b0, vt[i].sum, vt[i].co, vt[i].ov);
        end

        // Run and LoadB pulsed mid-CALC must be ignored
        load_b(16'h0001);
        d0 = dones;
        @(negedge Clk); SW = 16'h0005; Accum = 0; Run = 1;
        @(negedge Clk); Run = 0;
        @(negedge Clk); SW = 16'h1234; LoadB = 1; Run = 1;
        @(negedge Clk); LoadB = 0; Run = 0;
        lat = 0;
        while (!Done && lat < 200) begin @(negedge Clk); lat++; end
        check("ignore sum", {16'b0, Sum}, 16'h0006);
        repeat (N + 4) @(negedge Clk);
        check("ignore one_done", dones - d0, 1);
        run_check("ignore b_kept", 16'h0000, 0, 0, 16'h0001, 0, 0);

        // reset in the second CALC cycle aborts with no Done
        load_b(16'hC8F0);
        @(negedge Clk); SW = 16'hF8F0; Accum = 0; Run = 1;
        @(negedge Clk); Run = 0;
        @(negedge Clk);
        d0 = dones;
        Reset = 1; #1;
        check("abort sum", {16'b0, Sum}, 0);
        check("abort flags", {28'b0, CO, Overflow, Busy, Done}, 0);
        repeat (N + 3) @(negedge Clk);
        Reset = 0;
        repeat (N + 3) @(negedge Clk);
        check("abort no_done", dones - d0, 0);
        load_b(16'hC8F0);
        run_check("rerun", 16'hF8F0, 0, 0, 16'hC1E0, 1, 0);

`ifdef CHUNKED_ADDER_SUB_EN
        load_b(16'h0005);
        run_check("sub 3-5", 16'h0003, 0, 1, 16'hFFFE, 0, 0);
        load_b(16'h0003);
        run_check("sub 5-3", 16'h0005, 0, 1, 16'h0002, 1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
